// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo controller: TX FSM encoding,
// error-counter ceiling and the lowercase-to-uppercase conversion helper.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;
  localparam logic [7:0] LOWER_A       = 8'h61;
  localparam logic [7:0] LOWER_Z       = 8'h7A;
  localparam logic [7:0] CASE_OFFSET   = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= LOWER_A && b <= LOWER_Z) return b - CASE_OFFSET;
    return b;
  endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// Synchronous byte FIFO, 2^DEPTH_LOG2 entries, show-ahead read of the head
// entry; full/empty derive from the occupancy count.
module uart_echo_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/uart_echo_ctrl.sv
// Buffered UART echo: received bytes go through a FIFO and are handed back to
// the core transmitter one at a time. UART_ECHO_UPPERCASE_EN folds a..z to A..Z.
//
// state        | meaning
// ST_IDLE      | waiting for a buffered byte and an idle transmitter
// ST_SEND      | transmit pulse is high this cycle
// ST_WAIT_BUSY | waiting for the core to report busy
// ST_WAIT_DONE | waiting for the core to finish the byte
module uart_echo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  recv_error,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic [7:0]            err_count
);
  import uart_echo_pkg::*;

  logic       w_rx_ok;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;
  logic [7:0] w_tx_next;

  state_t     r_state;
  logic       r_transmit;
  logic [7:0] r_tx_byte;
  logic       r_overflow;
  logic [7:0] r_err_count;

  // A byte flagged with a framing error is discarded outright.
  assign w_rx_ok = received & ~recv_error;
  assign w_pop   = (r_state == ST_IDLE) & ~w_empty & ~is_transmitting;
  assign w_push  = w_rx_ok & (~w_full | w_pop);

`ifdef UART_ECHO_UPPERCASE_EN
  assign w_tx_next = to_upper(w_head);
`else
  assign w_tx_next = w_head;
`endif

  uart_echo_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (rx_byte),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_transmit <= 1'b0;
      r_tx_byte  <= 8'h00;
    end else begin
      r_transmit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_byte  <= w_tx_next;
            r_transmit <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND:      r_state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (is_transmitting)  r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!is_transmitting) r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      if (w_rx_ok && w_full && !w_pop) r_overflow <= 1'b1;
      if (recv_error && r_err_count != ERR_COUNT_MAX) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign transmit  = r_transmit;
  assign tx_byte   = r_tx_byte;
  assign overflow  = r_overflow;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl: vector table of echo bytes, a
// modelled UART core busy window, and a scoreboard of expected tx bytes.
module tb_uart_echo_ctrl;

  localparam int DL2 = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         received = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         recv_error = 1'b0;
  logic         is_transmitting = 1'b0;
  logic         transmit;
  logic [7:0]   tx_byte;
  logic [DL2:0] fifo_count;
  logic         overflow;
  logic [7:0]   err_count;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_tx = 0;
  int         busy_len = 100;
  int         rem = 0;
  logic       force_busy = 1'b0;
  logic       prev_tx = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx_plain;
    logic [7:0] tx_upper;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  uart_echo_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .clk             (clk),
    .rst             (rst),
    .received        (received),
    .rx_byte         (rx_byte),
    .recv_error      (recv_error),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .err_count       (err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmit monitor and UART core model: busy starts the cycle after transmit.
  always @(negedge clk) begin
    if (transmit === 1'b1) begin
      n_tx++;
      check("tx_back_to_back", {31'd0, prev_tx}, 0);
      check("tx_while_busy", {31'd0, is_transmitting}, 0);
      check("tx_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) check("tx_byte_order", tx_byte, exp_q.pop_front());
    end
    prev_tx = (transmit === 1'b1);
    if (rem > 0) begin
      is_transmitting = 1'b1;
      rem = rem - 1;
    end else begin
      is_transmitting = force_busy;
    end
    if (transmit === 1'b1) rem = busy_len;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && !is_transmitting && fifo_count == 0 && !transmit && rem == 0)
        done = 1'b1;
    end
    check(name, {31'd0, done}, 1);
    tick();
    tick();
  endtask

  task automatic echo_one(input logic [7:0] rx, input logic [7:0] exp);
    rx_byte  = rx;
    received = 1'b1;
    exp_q.push_back(exp);
    tick();
    received = 1'b0;
    check("cnt_after_push", fifo_count, 1);
    check("tx_low_n1", {31'd0, transmit}, 0);
    tick();
    check("tx_high_n2", {31'd0, transmit}, 1);
    check("tx_byte_n2", tx_byte, exp);
    check("cnt_after_pop", fifo_count, 0);
    wait_drain("echo_drain", 300);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    int saved_tx;

    vecs[0] = '{8'h41, 8'h41, 8'h41};
    vecs[1] = '{8'h61, 8'h61, 8'h41};
    vecs[2] = '{8'h7B, 8'h7B, 8'h7B};
    vecs[3] = '{8'h7A, 8'h7A, 8'h5A};
    vecs[4] = '{8'h60, 8'h60, 8'h60};
    vecs[5] = '{8'h00, 8'h00, 8'h00};
    vecs[6] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[7] = '{8'h5A, 8'h5A, 8'h5A};

    // reset held two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    tick();
    check("rst_transmit", {31'd0, transmit}, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
`ifdef UART_ECHO_UPPERCASE_EN
      e = vecs[i].tx_upper;
`else
      e = vecs[i].tx_plain;
`endif
      echo_one(vecs[i].rx, e);
    end

    // fill to full while the core is held busy
    force_busy = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      rx_byte  = i[7:0];
      received = 1'b1;
      exp_q.push_back(i[7:0]);
      tick();
    end
    received = 1'b0;
    check("cnt_full", fifo_count, 16);
    check("ovf_clear_at_full", {31'd0, overflow}, 0);
    force_busy = 1'b0;
    tick();
    // push lands in the same cycle as the first pop: accepted, no overflow
    rx_byte  = 8'h20;
    received = 1'b1;
    exp_q.push_back(8'h20);
    tick();
    check("cnt_push_pop_full", fifo_count, 16);
    check("ovf_push_pop_full", {31'd0, overflow}, 0);
    // FSM now in SEND with FIFO full: this byte must be dropped
    rx_byte = 8'h10;
    tick();
    received = 1'b0;
    check("cnt_after_drop", fifo_count, 16);
    check("ovf_after_drop", {31'd0, overflow}, 1);
    wait_drain("burst_drain", 2500);
    check("ovf_sticky", {31'd0, overflow}, 1);

    // error pulses, one coinciding with a received byte
    for (int i = 0; i < 300; i++) begin
      recv_error = 1'b1;
      if (i == 150) begin
        received = 1'b1;
        rx_byte  = 8'h55;
      end
      tick();
      recv_error = 1'b0;
      received   = 1'b0;
      if (i == 150) check("err_byte_not_pushed", fifo_count, 0);
      if (i == 253) check("err_count_254", err_count, 254);
      if (i == 254) check("err_count_255", err_count, 255);
      tick();
    end
    check("err_count_sat", err_count, 255);
    check("err_no_tx", {31'd0, transmit}, 0);

    // reset while waiting for the core to finish, three bytes still queued
    for (int i = 0; i < 4; i++) begin
      rx_byte  = 8'hA1 + i[7:0];
      received = 1'b1;
      exp_q.push_back(8'hA1 + i[7:0]);
      tick();
    end
    received = 1'b0;
    repeat (10) tick();
    check("mid_cnt", fifo_count, 3);
    check("mid_tx_byte", tx_byte, 8'hA1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cnt", fifo_count, 0);
    check("mid_rst_transmit", {31'd0, transmit}, 0);
    check("mid_rst_tx_byte", tx_byte, 8'h00);
    check("mid_rst_overflow", {31'd0, overflow}, 0);
    check("mid_rst_err_count", err_count, 0);
    exp_q.delete();
    saved_tx = n_tx;
    repeat (200) tick();
    check("no_tx_after_reset", n_tx, saved_tx);
    check("cnt_after_reset", fifo_count, 0);

    echo_one(8'h33, 8'h33);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
